vec_reg_file: RTL and testbench
===============================

# vec_reg_file

Parametrised vector register file for the accelerator datapath. It holds NUM_REGS vectors of N elements, each BITS wide, with a per-register length. It provides one handshaked write port, two registered read ports (A and B), and a sequenced bulk-clear engine. It sits between the instruction decoder and the vector ALU, and it has no tri-state outputs: unused read data is held, not floated.

## Interface
Parameters:
- BITS, 8, element width in bits
- N, 64, elements per vector
- NUM_REGS, 16, register count; a power of two, at least 2
- SEL_W, $clog2(NUM_REGS), register select width (derived, not overridden)
- LEN_W, $clog2(N+1), length field width (derived)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
- wr_sel  in  SEL_W  destination register
- wr_data  in  BITS x [N]  vector to write
- wr_len  in  LEN_W  vector length to write
- rd_a_req  in  1  read request, port A
- rd_a_sel  in  SEL_W  source register, port A
- rd_a_data  out  BITS x [N]  read data, port A
- rd_a_len  out  LEN_W  read length, port A
- rd_a_valid  out  1  A data valid, one-cycle pulse per request
- rd_b_req, rd_b_sel, rd_b_data, rd_b_len, rd_b_valid: same as the A port, for port B
- clr_req  in  1  start a bulk clear (single-cycle pulse)
- busy  out  1  clear engine active

## Operation
- Storage: NUM_REGS × N × BITS data, plus NUM_REGS × LEN_W lengths.
- Write: a write fires on a cycle with wr_valid && wr_ready. data[wr_sel] and len[wr_sel] update at that edge.
- Length saturation: wr_len > N is stored as N. Element data is stored in full regardless of length.
- Read ports:
  - A port with req high samples sel. rd_x_data, rd_x_len and rd_x_valid are registered on the next edge.
  - With req low, valid goes to 0 and data and len hold their previous values.
  - A and B are fully independent and may address the same register.
- Read/write collision (same register, same cycle): governed by the Configuration macro.
- State machine:
  - IDLE: wr_ready=1, busy=0. clr_req moves to CLEAR with sweep counter=0. If a write fires in the same cycle, that write commits first and is then cleared by the sweep.
  - CLEAR: wr_ready=0, busy=1. Each cycle zeroes data[counter] and len[counter], then increments counter. After register NUM_REGS-1 is zeroed, returns to IDLE. clr_req is ignored while in CLEAR.
  - Reads remain legal during CLEAR. A read of a register zeroed on that same edge follows the collision rule, with zero treated as the write value.
- Reset (rst_n=0 at an edge):
  - All data and lengths go to 0 and the state goes to IDLE.
  - Outputs: rd_a_valid=0, rd_b_valid=0, rd_a_data/rd_b_data all zeros, rd_a_len/rd_b_len=0, busy=0, wr_ready=1 from the first edge after rst_n rises. While rst_n=0, wr_ready=0.
  - Reset during CLEAR aborts the sweep.

## Timing
- Read latency: 1 cycle, from req sampled at edge k to valid/data at edge k+1. Back-to-back requests give valid every cycle.
- Write-to-read latency: 0 cycles with the macro defined, 1 cycle without.
- Clear duration: exactly NUM_REGS cycles with busy=1. wr_ready goes high on the first cycle after busy falls.
- No combinational path from any input to any output except wr_ready, which is a function of state and rst_n only.

## Configuration
- VEC_RF_BYPASS_EN defined: write-first forwarding. A read that targets the register being written (or cleared) on the same edge returns the new data and length.
- VEC_RF_BYPASS_EN undefined: read-first. Such a read returns the pre-write contents, and the new value is visible to reads requested on the following cycle.

## Test plan
- Write and read: write reg 3 with data[i]=i, len=10. Next cycle, A reads 3 and B reads 0. After 1 cycle: A data[i]=i, len=10, valid=1; B all zeros, len=0, valid=1.
- Saturation: write reg 5 with wr_len=N+1 (N=64, so 65). Read 5 returns len=64.
- Collision: reg 7 holds 0x11, then write 0x22 to reg 7 while A reads 7 in the same cycle. A returns 0x22 with VEC_RF_BYPASS_EN defined and 0x11 without.
- Clear: fill all 16 registers, pulse clr_req.
  - busy is high for exactly 16 cycles and wr_ready is low throughout.
  - A write held valid during the clear is accepted on the first cycle after busy falls.
  - Every register reads back zero with len=0.
- Reset mid-clear: drop rst_n on the 5th CLEAR cycle. After release: busy=0, wr_ready=1, all registers zero, and valid outputs stay 0 until a new req.
- Simultaneous clr_req and write in IDLE: write reg 2 with 0xAA together with clr_req. After the sweep, reg 2 reads zero.

Source files
------------

// File: rtl/vec_reg_file.sv
// Vector register file: NUM_REGS x N x BITS storage with lengths, one write port,
// two registered read ports and a bulk-clear sweep. Define VEC_RF_BYPASS_EN for write-first reads.
module vec_reg_file #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned N        = 64,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS),
    localparam int unsigned LEN_W   = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [N-1:0][BITS-1:0]    wr_data,
    input  logic [LEN_W-1:0]          wr_len,
    input  logic                      rd_a_req,
    input  logic [SEL_W-1:0]          rd_a_sel,
    output logic [N-1:0][BITS-1:0]    rd_a_data,
    output logic [LEN_W-1:0]          rd_a_len,
    output logic                      rd_a_valid,
    input  logic                      rd_b_req,
    input  logic [SEL_W-1:0]          rd_b_sel,
    output logic [N-1:0][BITS-1:0]    rd_b_data,
    output logic [LEN_W-1:0]          rd_b_len,
    output logic                      rd_b_valid,
    input  logic                      clr_req,
    output logic                      busy
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_CLEAR = 1'b1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(N);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

    logic [N-1:0][BITS-1:0] mem_data [NUM_REGS];
    logic [LEN_W-1:0]       mem_len  [NUM_REGS];

    logic [0:0]       state, state_nxt;
    logic [SEL_W-1:0] clr_cnt, clr_cnt_nxt;

    logic                   wr_fire;
    logic                   upd_en;
    logic [SEL_W-1:0]       upd_sel;
    logic [N-1:0][BITS-1:0] upd_data;
    logic [LEN_W-1:0]       upd_len;
    logic                   a_hit, b_hit;
    logic [N-1:0][BITS-1:0] a_data_c, b_data_c;
    logic [LEN_W-1:0]       a_len_c, b_len_c;

    assign wr_ready = rst_n && (state == ST_IDLE);
    assign busy     = (state == ST_CLEAR);
    assign wr_fire  = wr_valid && wr_ready;

    // Clear-engine state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state: sweep one register per cycle, ignore clr_req while sweeping
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == ST_IDLE) begin
            if (clr_req) begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        end else begin
            clr_cnt_nxt = clr_cnt + SEL_W'(1);
            if (clr_cnt == LAST_SEL) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Single storage update per edge: sweep zeroing in CLEAR, handshaked write in IDLE
    always_comb begin
        upd_en   = 1'b0;
        upd_sel  = wr_sel;
        upd_data = wr_data;
        upd_len  = (32'(wr_len) > N) ? LEN_MAX : wr_len;
        if (state == ST_CLEAR) begin
            upd_en   = 1'b1;
            upd_sel  = clr_cnt;
            upd_data = '0;
            upd_len  = '0;
        end else if (wr_fire) begin
            upd_en = 1'b1;
        end
    end

`ifdef VEC_RF_BYPASS_EN
    assign a_hit = upd_en && (rd_a_sel == upd_sel);
    assign b_hit = upd_en && (rd_b_sel == upd_sel);
`else
    assign a_hit = 1'b0;
    assign b_hit = 1'b0;
`endif

    always_comb begin
        a_data_c = a_hit ? upd_data : mem_data[rd_a_sel];
        a_len_c  = a_hit ? upd_len  : mem_len[rd_a_sel];
        b_data_c = b_hit ? upd_data : mem_data[rd_b_sel];
        b_len_c  = b_hit ? upd_len  : mem_len[rd_b_sel];
    end

    // Storage and registered read ports; read data holds when not requested
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_data[i] <= '0;
                mem_len[i]  <= '0;
            end
            rd_a_data  <= '0;
            rd_a_len   <= '0;
            rd_a_valid <= 1'b0;
            rd_b_data  <= '0;
            rd_b_len   <= '0;
            rd_b_valid <= 1'b0;
        end else begin
            if (upd_en) begin
                mem_data[upd_sel] <= upd_data;
                mem_len[upd_sel]  <= upd_len;
            end
            rd_a_valid <= rd_a_req;
            if (rd_a_req) begin
                rd_a_data <= a_data_c;
                rd_a_len  <= a_len_c;
            end
            rd_b_valid <= rd_b_req;
            if (rd_b_req) begin
                rd_b_data <= b_data_c;
                rd_b_len  <= b_len_c;
            end
        end
    end

endmodule

// File: tb/tb_vec_reg_file.sv
// Self-checking bench for vec_reg_file: table-driven write/read vectors, directed
// clear/reset/collision sequences, and a random phase checked against a behavioural model.
module tb_vec_reg_file;

    localparam int unsigned BITS     = 8;
    localparam int unsigned N        = 64;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned LEN_W    = 7;

`ifdef VEC_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef logic [N-1:0][BITS-1:0] vec_t;

    typedef struct {
        int         sel;
        int         len_in;
        logic [7:0] seed;
        int         exp_len;
    } wr_vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [SEL_W-1:0] wr_sel;
    vec_t             wr_data;
    logic [LEN_W-1:0] wr_len;
    logic             rd_a_req;
    logic [SEL_W-1:0] rd_a_sel;
    vec_t             rd_a_data;
    logic [LEN_W-1:0] rd_a_len;
    logic             rd_a_valid;
    logic             rd_b_req;
    logic [SEL_W-1:0] rd_b_sel;
    vec_t             rd_b_data;
    logic [LEN_W-1:0] rd_b_len;
    logic             rd_b_valid;
    logic             clr_req;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register contents, sweep position (-1 when idle), read outputs
    vec_t m_data [NUM_REGS];
    int   m_len  [NUM_REGS];
    int   m_clr = -1;
    vec_t m_a_data, m_b_data;
    int   m_a_len, m_b_len;
    bit   m_a_valid, m_b_valid;

    always #5 clk = ~clk;

    vec_reg_file #(.BITS(BITS), .N(N), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_len(wr_len),
        .rd_a_req(rd_a_req), .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
        .rd_a_len(rd_a_len), .rd_a_valid(rd_a_valid),
        .rd_b_req(rd_b_req), .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
        .rd_b_len(rd_b_len), .rd_b_valid(rd_b_valid),
        .clr_req(clr_req), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t ramp(input logic [7:0] seed);
        vec_t v;
        for (int i = 0; i < int'(N); i++) v[i] = seed + 8'(i);
        return v;
    endfunction

    function automatic vec_t fill(input logic [7:0] b);
        vec_t v;
        for (int i = 0; i < int'(N); i++) v[i] = b;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < int'(N); i++) v[i] = 8'($urandom);
        return v;
    endfunction

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_sel = '0; wr_data = '0; wr_len = '0;
        rd_a_req = 1'b0; rd_a_sel = '0; rd_b_req = 1'b0; rd_b_sel = '0;
        clr_req = 1'b0;
    endtask

    // One clock: predict from the current inputs, advance, compare every output
    task automatic tick();
        bit   w_en;
        int   w_sel, w_len;
        vec_t w_data;
        #1;
        chk("wr_ready", 64'(wr_ready), 64'(rst_n && (m_clr < 0)));
        if (!rst_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                m_data[r] = '0;
                m_len[r]  = 0;
            end
            m_clr = -1;
            m_a_valid = 0; m_a_data = '0; m_a_len = 0;
            m_b_valid = 0; m_b_data = '0; m_b_len = 0;
        end else begin
            w_en = 0; w_sel = 0; w_data = '0; w_len = 0;
            if (m_clr >= 0) begin
                w_en = 1; w_sel = m_clr;
            end else if (wr_valid) begin
                w_en = 1; w_sel = int'(wr_sel); w_data = wr_data;
                w_len = (int'(wr_len) > int'(N)) ? int'(N) : int'(wr_len);
            end
            m_a_valid = rd_a_req;
            if (rd_a_req) begin
                if (BYPASS && w_en && (w_sel == int'(rd_a_sel))) begin
                    m_a_data = w_data; m_a_len = w_len;
                end else begin
                    m_a_data = m_data[rd_a_sel]; m_a_len = m_len[rd_a_sel];
                end
            end
            m_b_valid = rd_b_req;
            if (rd_b_req) begin
                if (BYPASS && w_en && (w_sel == int'(rd_b_sel))) begin
                    m_b_data = w_data; m_b_len = w_len;
                end else begin
                    m_b_data = m_data[rd_b_sel]; m_b_len = m_len[rd_b_sel];
                end
            end
            if (w_en) begin
                m_data[w_sel] = w_data;
                m_len[w_sel]  = w_len;
            end
            if (m_clr >= 0) m_clr = (m_clr == int'(NUM_REGS) - 1) ? -1 : m_clr + 1;
            else if (clr_req) m_clr = 0;
        end
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_clr >= 0));
        chk("a_valid", 64'(rd_a_valid), 64'(m_a_valid));
        chk_vec("a_data", rd_a_data, m_a_data);
        chk("a_len", 64'(rd_a_len), 64'(m_a_len));
        chk("b_valid", 64'(rd_b_valid), 64'(m_b_valid));
        chk_vec("b_data", rd_b_data, m_b_data);
        chk("b_len", 64'(rd_b_len), 64'(m_b_len));
    endtask

    task automatic write_reg(input int sel, input vec_t d, input int len);
        wr_valid = 1'b1; wr_sel = SEL_W'(sel); wr_data = d; wr_len = LEN_W'(len);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_a(input int sel);
        rd_a_req = 1'b1; rd_a_sel = SEL_W'(sel);
        tick();
        rd_a_req = 1'b0;
    endtask

    task automatic wait_clear_done(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        chk({name, "_done"}, 64'(busy), 64'(0));
    endtask

    wr_vec_t tbl [6];
    int      busy_cnt;

    initial begin
        tbl[0] = '{3,  10,  8'h00, 10};
        tbl[1] = '{5,  65,  8'h40, 64};
        tbl[2] = '{15, 64,  8'h80, 64};
        tbl[3] = '{9,  0,   8'h33, 0};
        tbl[4] = '{1,  127, 8'hF0, 64};
        tbl[5] = '{12, 1,   8'h07, 1};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_wr_ready", 64'(wr_ready), 64'(1));
        chk("reset_a_valid", 64'(rd_a_valid), 64'(0));
        chk_vec("reset_a_data", rd_a_data, '0);

        // Table: write, then A reads it back while B reads the untouched reg 0
        for (int k = 0; k < 6; k++) begin
            write_reg(tbl[k].sel, ramp(tbl[k].seed), tbl[k].len_in);
            rd_b_req = 1'b1; rd_b_sel = '0;
            read_a(tbl[k].sel);
            rd_b_req = 1'b0;
            chk("tbl_a_valid", 64'(rd_a_valid), 64'(1));
            chk_vec("tbl_a_data", rd_a_data, ramp(tbl[k].seed));
            chk("tbl_a_len", 64'(rd_a_len), 64'(tbl[k].exp_len));
            chk("tbl_b_valid", 64'(rd_b_valid), 64'(1));
            chk_vec("tbl_b_data", rd_b_data, '0);
            chk("tbl_b_len", 64'(rd_b_len), 64'(0));
        end

        // Read/write collision on reg 7
        write_reg(7, fill(8'h11), 4);
        rd_a_req = 1'b1; rd_a_sel = 4'd7;
        write_reg(7, fill(8'h22), 6);
        rd_a_req = 1'b0;
        chk_vec("collide_a_data", rd_a_data, BYPASS ? fill(8'h22) : fill(8'h11));
        chk("collide_a_len", 64'(rd_a_len), BYPASS ? 64'(6) : 64'(4));
        read_a(7);
        chk_vec("collide_after", rd_a_data, fill(8'h22));

        // Held data when req drops
        tick();
        chk("hold_a_valid", 64'(rd_a_valid), 64'(0));
        chk_vec("hold_a_data", rd_a_data, fill(8'h22));

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_sel   = SEL_W'($urandom);
            wr_data  = rand_vec();
            wr_len   = LEN_W'($urandom);
            rd_a_req = 1'($urandom_range(0, 3) != 0);
            rd_a_sel = SEL_W'($urandom);
            rd_b_req = 1'($urandom_range(0, 3) != 0);
            rd_b_sel = SEL_W'($urandom);
            clr_req  = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle_inputs();
        for (int g = 0; g < 40 && m_clr >= 0; g++) tick();

        // Full clear with a write held pending across the sweep
        for (int r = 0; r < int'(NUM_REGS); r++) write_reg(r, rand_vec(), r + 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_sel = 4'd4; wr_data = fill(8'h5A); wr_len = 7'd20;
        busy_cnt = 0;
        for (int g = 0; g < 40 && busy; g++) begin
            busy_cnt++;
            chk("clear_wr_ready_low", 64'(wr_ready), 64'(0));
            tick();
        end
        chk("clear_busy_cycles", 64'(busy_cnt), 64'(NUM_REGS));
        chk("clear_wr_ready_high", 64'(wr_ready), 64'(1));
        tick();
        wr_valid = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            read_a(r);
            chk_vec("clear_rd_data", rd_a_data, (r == 4) ? fill(8'h5A) : vec_t'('0));
            chk("clear_rd_len", 64'(rd_a_len), (r == 4) ? 64'(20) : 64'(0));
        end

        // Reset on the 5th sweep cycle
        write_reg(10, fill(8'h3C), 9);
        write_reg(14, fill(8'hC3), 9);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (4) tick();
        chk("midclr_busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midclr_busy", 64'(busy), 64'(0));
        chk("midclr_wr_ready", 64'(wr_ready), 64'(1));
        chk("midclr_a_valid", 64'(rd_a_valid), 64'(0));
        chk("midclr_b_valid", 64'(rd_b_valid), 64'(0));
        tick();
        chk("midclr_a_valid2", 64'(rd_a_valid), 64'(0));
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            read_a(r);
            chk_vec("midclr_rd_data", rd_a_data, '0);
            chk("midclr_rd_len", 64'(rd_a_len), 64'(0));
        end

        // Write and clr_req in the same idle cycle: write lands, then gets swept
        wr_valid = 1'b1; wr_sel = 4'd2; wr_data = fill(8'hAA); wr_len = 7'd8;
        clr_req = 1'b1;
        tick();
        idle_inputs();
        chk("simul_busy", 64'(busy), 64'(1));
        wait_clear_done("simul");
        read_a(2);
        chk_vec("simul_rd_data", rd_a_data, '0);
        chk("simul_rd_len", 64'(rd_a_len), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
